// File: rtl/fir_spi_master.sv
`timescale 1ns/1ps
// fir_spi_master: SPI master (CPOL=0, CPHA=0) that frames one packet of
//   SAMPLES_NUM 16-bit samples, zero-padded to PACKET_SIZE bytes, and
//   captures the same number of MISO bits. SCK half-period is CLK_DIV clocks.
// Latency: ssOut falls one cycle after accept; doneOut pulses
//   1 + 2*CLK_DIV*N + CLK_DIV cycles after accept; busyOut drops CLK_DIV later.
// Backpressure: none; startIn is ignored while busyOut is high (no queueing).
// Ports:
//   clkIn, resetIn (sync, active-high)  startIn/abortIn  request/terminate
//   dataIn   samples, first sample in the top 16 bits
//   misoIn   serial input, already synchronous to clkIn
//   ssOut/sckOut/mosiOut  SPI pins    dataOut/doneOut  received word + pulse
//   busyOut  high from accept until the inter-packet gap ends
module fir_spi_master #(
  parameter int PACKET_SIZE = 8,
  parameter int SAMPLES_NUM = 2,
  parameter int CLK_DIV     = 4
) (
  input  logic                        clkIn,
  input  logic                        resetIn,
  input  logic                        startIn,
  input  logic                        abortIn,
  input  logic [SAMPLES_NUM*16-1:0]   dataIn,
  input  logic                        misoIn,
  output logic                        ssOut,
  output logic                        sckOut,
  output logic                        mosiOut,
  output logic [PACKET_SIZE*8-1:0]    dataOut,
  output logic                        doneOut,
  output logic                        busyOut
);

  localparam int N   = PACKET_SIZE * 8;
  localparam int TXW = SAMPLES_NUM * 16;
  localparam int CW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW  = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [N-1:0]    tx_q, tx_d;
  logic [N-1:0]    rx_q, rx_d;
  logic [N-1:0]    data_q, data_d;
  logic            ss_q, ss_d;
  logic            sck_q, sck_d;
  logic            mosi_q, mosi_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic [N-1:0]    tx_load;
  logic            cnt_end;

  // Samples occupy the top of the frame; the tail is zero padding.
  always_comb begin
    tx_load = '0;
    tx_load[N-1 -: TXW] = dataIn;
  end

  assign cnt_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    data_d  = data_q;
    ss_d    = ss_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    busy_d  = busy_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (startIn && !abortIn) begin
          tx_d    = tx_load;
          bit_d   = '0;
          ss_d    = 1'b0;
          mosi_d  = tx_load[N-1];
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_end) begin
          cnt_d   = '0;
          sck_d   = 1'b1;
          rx_d    = {rx_q[N-2:0], misoIn};
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (cnt_end) begin
          cnt_d = '0;
          sck_d = 1'b0;
          if (bit_q != BIT_LAST) begin
            // Next bit is presented on the falling edge (CPHA=0).
            tx_d    = tx_q << 1;
            mosi_d  = tx_q[N-2];
            bit_d   = bit_q + BW'(1);
            state_d = S_LOW;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_LOW: begin
        if (cnt_end) begin
          cnt_d   = '0;
          sck_d   = 1'b1;
          rx_d    = {rx_q[N-2:0], misoIn};
          state_d = S_HIGH;
        end
      end
      S_HOLD: begin
        if (cnt_end) begin
          cnt_d   = '0;
          ss_d    = 1'b1;
          mosi_d  = 1'b0;
          data_d  = rx_q;
          done_d  = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_end) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides any timed transition; the gap still runs in full so
    // the slave sees a proper deselect interval, and dataOut is untouched.
    if (abortIn && (state_q inside {S_SETUP, S_HIGH, S_LOW, S_HOLD})) begin
      cnt_d   = '0;
      ss_d    = 1'b1;
      sck_d   = 1'b0;
      mosi_d  = 1'b0;
      data_d  = data_q;
      done_d  = 1'b0;
      state_d = S_GAP;
    end
  end

  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      ss_q    <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      ss_q    <= ss_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign ssOut   = ss_q;
  assign sckOut  = sck_q;
  assign mosiOut = mosi_q;
  assign dataOut = data_q;
  assign doneOut = done_q;
  assign busyOut = busy_q;

endmodule

// File: tb/tb_fir_spi_master.sv
`timescale 1ns/1ps
// Testbench for fir_spi_master: default instance (N=64, CLK_DIV=4) plus a
// small instance (SAMPLES_NUM=1, PACKET_SIZE=4, CLK_DIV=2).
// Cycle c: inputs set while cyc==c are sampled at posedge c; outputs observed
// while cyc==c are those present at posedge c.
module tb_fir_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        rst, start, abort, miso;
  logic [31:0] din;
  logic        ss, sck, mosi, done, busy;
  logic [63:0] dout;

  // small instance
  logic        start2, miso2;
  logic [15:0] din2;
  logic        ss2, sck2, mosi2, done2, busy2;
  logic [31:0] dout2;

  fir_spi_master dut (
    .clkIn(clk), .resetIn(rst), .startIn(start), .abortIn(abort),
    .dataIn(din), .misoIn(miso), .ssOut(ss), .sckOut(sck), .mosiOut(mosi),
    .dataOut(dout), .doneOut(done), .busyOut(busy)
  );

  fir_spi_master #(.PACKET_SIZE(4), .SAMPLES_NUM(1), .CLK_DIV(2)) dut2 (
    .clkIn(clk), .resetIn(rst), .startIn(start2), .abortIn(1'b0),
    .dataIn(din2), .misoIn(miso2), .ssOut(ss2), .sckOut(sck2), .mosiOut(mosi2),
    .dataOut(dout2), .doneOut(done2), .busyOut(busy2)
  );

  // Slave model: presents bit 63 while selected, shifts after each SCK fall.
  logic        loop_mode;
  logic [63:0] slv_val, slv_sh;
  logic        prev_sck;
  always @(posedge clk) begin
    prev_sck <= sck;
    if (ss)
      slv_sh <= slv_val;
    else if (prev_sck && !sck)
      slv_sh <= slv_sh << 1;
  end
  assign miso  = loop_mode ? mosi : slv_sh[63];
  assign miso2 = mosi2;

  int total = 0;
  int bad   = 0;
  int cyc;

  // recorded observations
  int          done_cyc, done_cnt, busy_fall, ss_low, rises, ss_bad, mosi_bad, probe;
  logic [63:0] stream;
  logic        sck_prev, mosi_prev;
  logic        p_ss, p_sck, p_mosi, p_busy, p_done;
  logic [63:0] p_dout;
  int          done2_cyc, rises2;
  logic [31:0] stream2;
  logic        sck2_prev;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_rec();
    done_cyc = -1; done_cnt = 0; busy_fall = -1; ss_low = -1;
    rises = 0; ss_bad = 0; mosi_bad = 0; stream = '0;
    sck_prev = sck; mosi_prev = mosi;
    p_ss = 1'bx; p_sck = 1'bx; p_mosi = 1'bx; p_busy = 1'bx; p_done = 1'bx; p_dout = 'x;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    if (!busy && busy_fall < 0) busy_fall = cyc;
    if (!ss && ss_low < 0) ss_low = cyc;
    if (!sck_prev && sck) begin
      rises++;
      if (ss) ss_bad++;
      if (mosi !== mosi_prev) mosi_bad++;
      stream = {stream[62:0], mosi};
    end
    sck_prev  = sck;
    mosi_prev = mosi;
    if (cyc == probe) begin
      p_ss = ss; p_sck = sck; p_mosi = mosi; p_busy = busy; p_done = done; p_dout = dout;
    end
    if (!sck2_prev && sck2) begin
      rises2++;
      stream2 = {stream2[30:0], mosi2};
    end
    sck2_prev = sck2;
    if (done2 && done2_cyc < 0) done2_cyc = cyc;
  endtask

  // One packet on the default instance; accept at posedge 0, runs to end_cyc.
  task automatic pkt(input logic [31:0] d, input int end_cyc, input int abort_at,
                     input int reset_at, input int s1, input int s2, input int probe_at);
    clear_rec();
    probe = probe_at;
    cyc   = 0;
    din   = d;
    start = 1'b1;
    while (cyc < end_cyc) begin
      step();
      start = (cyc == s1) || (cyc == s2);
      abort = (cyc == abort_at);
      rst   = (cyc == reset_at);
      if (cyc == 1) din = ~d;   // later changes must not leak into the packet
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; din = '0;
    start2 = 1'b0; din2 = '0;
    loop_mode = 1'b1; slv_val = '0;
    cyc = 0; probe = -1;
    done2_cyc = -1; rises2 = 0; stream2 = '0; sck2_prev = 1'b0;
    clear_rec();
    repeat (3) step();

    // reset state
    chk("rst_ss",   ss,   1'b1);
    chk("rst_sck",  sck,  1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_dout", dout, 64'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ss2",  ss2,  1'b1);
    rst = 1'b0;
    step();

    // loopback packet
    loop_mode = 1'b1;
    pkt(32'h1234ABCD, 521, -1, -1, -1, -1, -1);
    chk("lb_ss_low",   ss_low,    1);
    chk("lb_stream",   stream,    64'h1234ABCD00000000);
    chk("lb_dout",     dout,      64'h1234ABCD00000000);
    chk("lb_done_cyc", done_cyc,  517);
    chk("lb_done_cnt", done_cnt,  1);
    chk("lb_rises",    rises,     64);
    chk("lb_busy_low", busy_fall, 521);

    // slave returns a fixed word; stray starts at 100 and 300
    loop_mode = 1'b0;
    slv_val   = 64'hDEADBEEF01234567;
    pkt(32'h0F0F5A5A, 521, -1, -1, 100, 300, -1);
    chk("sl_dout",     dout,      64'hDEADBEEF01234567);
    chk("sl_stream",   stream,    64'h0F0F5A5A00000000);
    chk("sl_rises",    rises,     64);
    chk("sl_ss_bad",   ss_bad,    0);
    chk("sl_mosi_bad", mosi_bad,  0);
    chk("sl_done_cyc", done_cyc,  517);
    chk("sl_done_cnt", done_cnt,  1);
    chk("sl_busy_low", busy_fall, 521);

    // back-to-back start (accept at old cycle 521), aborted at 200
    pkt(32'hCAFE0001, 210, 200, -1, -1, -1, 201);
    chk("ab_ss_low",   ss_low,    1);
    chk("ab_ss",       p_ss,      1'b1);
    chk("ab_sck",      p_sck,     1'b0);
    chk("ab_mosi",     p_mosi,    1'b0);
    chk("ab_rises",    rises,     25);
    chk("ab_done_cnt", done_cnt,  0);
    chk("ab_dout",     dout,      64'hDEADBEEF01234567);
    chk("ab_busy_low", busy_fall, 205);

    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("sa_ss",   ss,   1'b1);
    chk("sa_busy", busy, 1'b0);
    step();
    chk("sa_busy2", busy, 1'b0);

    // reset mid-packet
    loop_mode = 1'b1;
    pkt(32'h55AA33CC, 155, -1, 150, -1, -1, 151);
    chk("rs_ss",       p_ss,     1'b1);
    chk("rs_sck",      p_sck,    1'b0);
    chk("rs_mosi",     p_mosi,   1'b0);
    chk("rs_busy",     p_busy,   1'b0);
    chk("rs_done",     p_done,   1'b0);
    chk("rs_dout",     p_dout,   64'h0);
    chk("rs_done_cnt", done_cnt, 0);

    // small instance: one sample, 4-byte packet, CLK_DIV=2
    done2_cyc = -1; rises2 = 0; stream2 = '0; sck2_prev = sck2;
    cyc = 0; din2 = 16'h8001; start2 = 1'b1;
    while (cyc < 135) begin
      step();
      start2 = 1'b0;
      if (cyc == 1) din2 = 16'h0000;
    end
    chk("sm_stream",   stream2,   32'h80010000);
    chk("sm_rises",    rises2,    32);
    chk("sm_done_cyc", done2_cyc, 131);
    chk("sm_dout",     dout2,     32'h80010000);
    chk("sm_busy",     busy2,     1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
